// File: rtl/hub75_mon_pkg.sv
// -----------------------------------------------------------------------------
// hub75_mon_pkg
// Shared definitions for the HUB75 scan monitor:
//   - mon_state_t : run-state encoding used by the monitor FSM
//   - DEF_*       : default geometry, counter width, thresholds and timeout
// No ports (package).
// -----------------------------------------------------------------------------
package hub75_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } mon_state_t;

    localparam int DEF_ROW_BITS    = 32'd5;
    localparam int DEF_RGB_BITS    = 32'd3;
    localparam int DEF_CNT_W       = 32'd16;
    // 50 ms at a 25 MHz system clock
    localparam int DEF_TIMEOUT_CYC = 32'd1_250_000;
    localparam int DEF_FRAMES_REQ  = 32'd3;
    localparam int DEF_PIX_MIN     = 32'd100;

endpackage

// File: rtl/hub75_scan_monitor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset (count -> 0)
//   i_clr   : synchronous clear (count -> 0)
//   i_inc   : increment request, ignored once saturated
//   o_count : current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] L_MAX = {W{1'b1}};
    localparam logic [W-1:0] L_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    // Count register: reset/clear first, then saturating increment
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {W{1'b0}};
        end else if (i_clr) begin
            r_count <= {W{1'b0}};
        end else if (i_inc && (r_count != L_MAX)) begin
            r_count <= r_count + L_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hub75_scan_monitor.sv
// -----------------------------------------------------------------------------
// hub75_scan_monitor
// Watches a HUB75 panel bus for one run (start -> PASS/FAIL): counts frames
// (row address wrapping to 0), lit-pixel events and row-sequence violations.
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   start               : one-cycle run request (ignored while running)
//   LP_CLK, NOE, ROW,
//   RGB0, RGB1          : panel bus, registered once before use
//   frame_count         : frames seen in the current run
//   pixel_count         : lit-pixel events (saturating)
//   row_err_count       : row-sequence violations (saturating)
//   frame_pulse         : one-cycle strobe per detected frame
//   busy/done/pass/fail : registered run status
// -----------------------------------------------------------------------------
module hub75_scan_monitor
    import hub75_mon_pkg::*;
#(
    parameter int ROW_BITS    = DEF_ROW_BITS,
    parameter int RGB_BITS    = DEF_RGB_BITS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int FRAMES_REQ  = DEF_FRAMES_REQ,
    parameter int PIX_MIN     = DEF_PIX_MIN,
    parameter int PIX_MODE    = 32'd0,
    parameter int STRICT      = 32'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                LP_CLK,
    input  logic                NOE,
    input  logic [ROW_BITS-1:0] ROW,
    input  logic [RGB_BITS-1:0] RGB0,
    input  logic [RGB_BITS-1:0] RGB1,
    output logic [CNT_W-1:0]    frame_count,
    output logic [CNT_W-1:0]    pixel_count,
    output logic [CNT_W-1:0]    row_err_count,
    output logic                frame_pulse,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TO_W-1:0]     L_TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0]     L_TO_ONE     = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_BITS-1:0] L_ROW_ONE    = {{(ROW_BITS-1){1'b0}}, 1'b1};
    localparam logic [ROW_BITS-1:0] L_ROW_ZERO   = {ROW_BITS{1'b0}};
    localparam logic [ROW_BITS-1:0] L_ROW_ONES   = {ROW_BITS{1'b1}};
    localparam logic [CNT_W-1:0]    L_FRAMES_REQ = CNT_W'(FRAMES_REQ);
    localparam logic [CNT_W-1:0]    L_PIX_MIN    = CNT_W'(PIX_MIN);
    localparam logic [CNT_W-1:0]    L_CNT_ZERO   = {CNT_W{1'b0}};

    // Registered copies of the panel bus; r_lp_clk_d is one more stage for edge detect
    logic                r_lp_clk;
    logic                r_lp_clk_d;
    logic                r_noe;
    logic [ROW_BITS-1:0] r_row;
    logic [RGB_BITS-1:0] r_rgb0;
    logic [RGB_BITS-1:0] r_rgb1;

    mon_state_t          r_state;
    mon_state_t          w_state_nxt;
    logic [ROW_BITS-1:0] r_last_row;
    logic                r_first_chg;   // next row change is exempt from the sequence check
    logic [TO_W-1:0]     r_timeout;
    logic                r_frame_pulse;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                r_fail;

    logic w_run;
    logic w_clr;
    logic w_lit;
    logic w_lp_rise;
    logic w_pix_evt;
    logic w_row_chg;
    logic w_frame_det;
    logic w_row_err;
    logic w_pass_cond;
    logic w_fail_cond;

    // Panel input register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lp_clk   <= 1'b0;
            r_lp_clk_d <= 1'b0;
            r_noe      <= 1'b1;
            r_row      <= L_ROW_ZERO;
            r_rgb0     <= {RGB_BITS{1'b0}};
            r_rgb1     <= {RGB_BITS{1'b0}};
        end else begin
            r_lp_clk   <= LP_CLK;
            r_lp_clk_d <= r_lp_clk;
            r_noe      <= NOE;
            r_row      <= ROW;
            r_rgb0     <= RGB0;
            r_rgb1     <= RGB1;
        end
    end

    assign w_run       = (r_state == ST_RUN);
    // A start request is accepted in every state except RUN
    assign w_clr       = start && !w_run;
    assign w_lit       = !r_noe && ((r_rgb0 | r_rgb1) != {RGB_BITS{1'b0}});
    assign w_lp_rise   = r_lp_clk && !r_lp_clk_d;
    assign w_pix_evt   = (PIX_MODE != 0) ? (w_lit && w_lp_rise) : w_lit;
    assign w_row_chg   = (r_row != r_last_row);
    assign w_frame_det = w_run && (r_row == L_ROW_ZERO) && (r_last_row != L_ROW_ZERO);
    // Expected successor wraps naturally within ROW_BITS
    assign w_row_err   = w_run && w_row_chg && !r_first_chg && (r_row != (r_last_row + L_ROW_ONE));
    assign w_pass_cond = (frame_count >= L_FRAMES_REQ) && (pixel_count > L_PIX_MIN);
    assign w_fail_cond = (r_timeout == L_TO_LAST) ||
                         ((STRICT != 0) && (row_err_count != L_CNT_ZERO));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; PASS is checked before FAIL so it wins a tie
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
                else       w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (w_pass_cond)      w_state_nxt = ST_PASS;
                else if (w_fail_cond) w_state_nxt = ST_FAIL;
                else                  w_state_nxt = ST_RUN;
            end
            ST_PASS, ST_FAIL: begin
                if (start) w_state_nxt = ST_RUN;
                else       w_state_nxt = r_state;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the next state so they line up with r_state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_RUN);
            r_done <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL);
            r_pass <= (w_state_nxt == ST_PASS);
            r_fail <= (w_state_nxt == ST_FAIL);
        end
    end

    // Row history: all ones at run start so row 0 immediately counts as a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_row  <= L_ROW_ONES;
            r_first_chg <= 1'b1;
        end else if (w_clr) begin
            r_last_row  <= L_ROW_ONES;
            r_first_chg <= 1'b1;
        end else if (w_run) begin
            r_last_row  <= r_row;
            r_first_chg <= r_first_chg && !w_row_chg;
        end else begin
            r_last_row  <= r_last_row;
            r_first_chg <= r_first_chg;
        end
    end

    // Run timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= {TO_W{1'b0}};
        end else if (w_clr) begin
            r_timeout <= {TO_W{1'b0}};
        end else if (w_run) begin
            r_timeout <= r_timeout + L_TO_ONE;
        end else begin
            r_timeout <= r_timeout;
        end
    end

    // Frame strobe, aligned with the frame_count increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_pulse <= 1'b0;
        end else begin
            r_frame_pulse <= w_frame_det;
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_inc   (w_frame_det),
        .o_count (frame_count)
    );

    sat_counter #(.W(CNT_W)) u_pixel_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_inc   (w_run && w_pix_evt),
        .o_count (pixel_count)
    );

    sat_counter #(.W(CNT_W)) u_row_err_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_inc   (w_row_err),
        .o_count (row_err_count)
    );

    assign frame_pulse = r_frame_pulse;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;

endmodule

// File: tb/tb_hub75_scan_monitor.sv
// -----------------------------------------------------------------------------
// tb_hub75_scan_monitor
// Three monitor instances on one shared 8-row panel bus:
//   dut0: PIX_MODE=0 STRICT=0 TIMEOUT=200
//   dut1: PIX_MODE=1 STRICT=1 TIMEOUT=200
//   dut2: PIX_MODE=0 STRICT=0 TIMEOUT=18 (pass and timeout land together)
// Each directed run pushes its hand-computed end result into a queue; a monitor
// process pops and compares whenever an instance raises done.
// -----------------------------------------------------------------------------
module tb_hub75_scan_monitor;

    typedef struct {
        int dut;
        int pass;
        int fail;
        int frames;
        int pixels;
        int errs;
        int lat;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic       lp_in = 1'b0;
    logic       noe_in = 1'b1;
    logic [2:0] row_in = 3'd7;
    logic [2:0] rgb0_in = 3'b000;
    logic [2:0] rgb1_in = 3'b000;

    wire [2:0][15:0] m_fc;
    wire [2:0][15:0] m_px;
    wire [2:0][15:0] m_er;
    wire [2:0]       m_pulse;
    wire [2:0]       m_busy;
    wire [2:0]       m_done;
    wire [2:0]       m_pass;
    wire [2:0]       m_fail;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_seen = 0;
    exp_t q_exp[$];

    always #5 clk = ~clk;

    // Free-running edge counter used to time run completion
    always @(posedge clk) cyc <= cyc + 1;

    hub75_scan_monitor #(.ROW_BITS(3), .RGB_BITS(3), .CNT_W(16), .TIMEOUT_CYC(200),
                         .FRAMES_REQ(3), .PIX_MIN(10), .PIX_MODE(0), .STRICT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .LP_CLK(lp_in), .NOE(noe_in),
        .ROW(row_in), .RGB0(rgb0_in), .RGB1(rgb1_in),
        .frame_count(m_fc[0]), .pixel_count(m_px[0]), .row_err_count(m_er[0]),
        .frame_pulse(m_pulse[0]), .busy(m_busy[0]), .done(m_done[0]),
        .pass(m_pass[0]), .fail(m_fail[0]));

    hub75_scan_monitor #(.ROW_BITS(3), .RGB_BITS(3), .CNT_W(16), .TIMEOUT_CYC(200),
                         .FRAMES_REQ(3), .PIX_MIN(10), .PIX_MODE(1), .STRICT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .LP_CLK(lp_in), .NOE(noe_in),
        .ROW(row_in), .RGB0(rgb0_in), .RGB1(rgb1_in),
        .frame_count(m_fc[1]), .pixel_count(m_px[1]), .row_err_count(m_er[1]),
        .frame_pulse(m_pulse[1]), .busy(m_busy[1]), .done(m_done[1]),
        .pass(m_pass[1]), .fail(m_fail[1]));

    hub75_scan_monitor #(.ROW_BITS(3), .RGB_BITS(3), .CNT_W(16), .TIMEOUT_CYC(18),
                         .FRAMES_REQ(3), .PIX_MIN(10), .PIX_MODE(0), .STRICT(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .LP_CLK(lp_in), .NOE(noe_in),
        .ROW(row_in), .RGB0(rgb0_in), .RGB1(rgb1_in),
        .frame_count(m_fc[2]), .pixel_count(m_px[2]), .row_err_count(m_er[2]),
        .frame_pulse(m_pulse[2]), .busy(m_busy[2]), .done(m_done[2]),
        .pass(m_pass[2]), .fail(m_fail[2]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int p, input int f, input int fr,
                                input int px, input int er, input int lat);
        exp_t e;
        e.dut = 0; e.pass = p; e.fail = f; e.frames = fr;
        e.pixels = px; e.errs = er; e.lat = lat; e.cyc = 0;
        return e;
    endfunction

    task automatic chk_zero(input int d);
        chk($sformatf("rst_dut%0d_frames", d), int'(m_fc[d]), 0);
        chk($sformatf("rst_dut%0d_pixels", d), int'(m_px[d]), 0);
        chk($sformatf("rst_dut%0d_errs", d), int'(m_er[d]), 0);
        chk($sformatf("rst_dut%0d_status", d),
            int'({m_pulse[d], m_busy[d], m_done[d], m_pass[d], m_fail[d]}), 0);
    endtask

    // mode 0: ideal scan lit on RGB0; 1: dark; 2: row skip 5->7 lit;
    // 3: ideal scan, RGB1 lit, LP_CLK toggling every 2 cycles
    task automatic run_scan(input int d, input int mode, input int nsteps,
                            input bit push, input exp_t e);
        exp_t x;
        int   r;
        @(posedge clk); #1;
        start_v = 3'b000; lp_in = 1'b0; noe_in = 1'b1;
        rgb0_in = 3'b000; rgb1_in = 3'b000; row_in = 3'd7;
        for (int s = 0; s < nsteps; s++) begin
            @(posedge clk); #1;
            start_v = 3'b000;
            if (s == 0) begin
                start_v[d] = 1'b1;
                if (push) begin
                    x = e;
                    x.dut = d;
                    x.cyc = cyc + 1 + e.lat;
                    q_exp.push_back(x);
                end
            end
            r = (mode == 2 && s > 5) ? s + 1 : s;
            row_in  = 3'(r % 8);
            noe_in  = 1'b0;
            rgb0_in = (mode == 0 || mode == 2) ? 3'b001 : 3'b000;
            rgb1_in = (mode == 3) ? 3'b100 : 3'b000;
            lp_in   = (mode == 3) ? (((s / 2) % 2) == 1) : 1'b0;
        end
        @(posedge clk); #1;
        start_v = 3'b000;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && q_exp.size() != 0; i++) @(posedge clk);
        chk({name, "_drained"}, q_exp.size(), 0);
    endtask

    // Monitor: compares each completed run against the queued expectation
    initial begin
        bit   prev_done[3];
        bit   prev_busy[3];
        int   pulses[3];
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            prev_done[d] = 1'b0; prev_busy[d] = 1'b0; pulses[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (m_busy[d] && !prev_busy[d]) pulses[d] = 0;
                if (m_pulse[d]) pulses[d]++;
                if (m_done[d] && !prev_done[d]) begin
                    if (q_exp.size() == 0) begin
                        chk($sformatf("unexpected_done_dut%0d", d), 1, 0);
                    end else begin
                        e = q_exp.pop_front();
                        n_seen++;
                        chk("run_dut_id", d, e.dut);
                        chk($sformatf("dut%0d_pass", d), int'(m_pass[d]), e.pass);
                        chk($sformatf("dut%0d_fail", d), int'(m_fail[d]), e.fail);
                        chk($sformatf("dut%0d_busy", d), int'(m_busy[d]), 0);
                        chk($sformatf("dut%0d_frames", d), int'(m_fc[d]), e.frames);
                        chk($sformatf("dut%0d_pixels", d), int'(m_px[d]), e.pixels);
                        chk($sformatf("dut%0d_row_errs", d), int'(m_er[d]), e.errs);
                        chk($sformatf("dut%0d_done_cycle", d), cyc, e.cyc);
                        chk($sformatf("dut%0d_pulses", d), pulses[d], e.frames);
                    end
                end
                prev_done[d] = m_done[d];
                prev_busy[d] = m_busy[d];
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_zero(d);
        rst = 1'b0;

        // ideal scan from IDLE -> PASS
        run_scan(0, 0, 25, 1'b1, mk(1, 0, 3, 18, 0, 18));
        wait_drain("ideal");
        // dark panel, restarted from PASS -> timeout FAIL
        run_scan(0, 1, 205, 1'b1, mk(0, 1, 25, 0, 0, 200));
        wait_drain("dark");
        // row skip with STRICT -> FAIL the cycle after the error appears
        run_scan(1, 2, 12, 1'b1, mk(0, 1, 2, 0, 1, 8));
        wait_drain("skip_strict");
        // row skip without STRICT, restarted from FAIL -> PASS
        run_scan(0, 2, 25, 1'b1, mk(1, 0, 3, 17, 1, 17));
        wait_drain("skip_loose");
        // LP_CLK-qualified pixel counting -> 11 rises, not clk cycles
        run_scan(1, 3, 50, 1'b1, mk(1, 0, 6, 11, 0, 44));
        wait_drain("lp_mode");
        // pass condition and timeout in the same cycle -> PASS
        run_scan(2, 0, 25, 1'b1, mk(1, 0, 3, 18, 0, 18));
        wait_drain("tie");

        // reset in the middle of a run, then a clean restart
        run_scan(0, 0, 5, 1'b0, mk(0, 0, 0, 0, 0, 0));
        chk("midrun_busy", int'(m_busy[0]), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero(0);
        rst = 1'b0;
        run_scan(0, 0, 25, 1'b1, mk(1, 0, 3, 18, 0, 18));
        wait_drain("after_rst");

        repeat (3) @(posedge clk);
        chk("runs_seen", n_seen, 7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
